// File: rtl/mul_div_unit_if.sv
// Issue and CDB mul-lane signals of the multiply/divide unit.
// master = reservation station / CDB side, slave = the unit.
interface mul_div_unit_if;
   logic        issue_valid;
   logic        issue_ready;
   logic [2:0]  issue_multop;
   logic [31:0] issue_rs1_data;
   logic [31:0] issue_rs2_data;
   logic [4:0]  issue_rob_idx;
   logic [4:0]  issue_rd_addr;
   logic        cdb_ready;
   logic        mul_valid;
   logic [31:0] mul_data;
   logic [4:0]  mul_rob_idx;
   logic [4:0]  mul_rd_addr;

   modport master (
      output issue_valid, issue_multop, issue_rs1_data, issue_rs2_data,
             issue_rob_idx, issue_rd_addr, cdb_ready,
      input  issue_ready, mul_valid, mul_data, mul_rob_idx, mul_rd_addr
   );

   modport slave (
      input  issue_valid, issue_multop, issue_rs1_data, issue_rs2_data,
             issue_rob_idx, issue_rd_addr, cdb_ready,
      output issue_ready, mul_valid, mul_data, mul_rob_idx, mul_rd_addr
   );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: 2-stage multiplier, 32-step restoring divider,
// one operation in flight, result held on the CDB mul lane until granted.
module mul_div_unit (
   input logic           clk,
   input logic           rst,
   input logic           flush,
   mul_div_unit_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        neg_a_q, neg_b_q;
   logic [31:0] rem_q, quo_q, dvs_q;
   logic [63:0] prod_q;
   logic [31:0] result_q;
   logic        mul_valid_q;
   logic [31:0] mul_data_q;
   logic [4:0]  rob_q, rd_q;

   // Issue-side decode, used only at acceptance.
   logic        in_is_div, in_signed, in_div_zero, in_div_ovf;
   logic [31:0] in_rs1, in_rs2;

   always_comb begin
      in_rs1      = bus.issue_rs1_data;
      in_rs2      = bus.issue_rs2_data;
      in_is_div   = bus.issue_multop[2];
      in_signed   = ~bus.issue_multop[0];
      in_div_zero = in_is_div && (in_rs2 == 32'h0);
      in_div_ovf  = in_is_div && in_signed && (in_rs1 == 32'h8000_0000)
                    && (in_rs2 == 32'hFFFF_FFFF);
   end

   // Multiplier operands sign-/zero-extended to 64 bits; low 64 bits of the
   // product are then correct for every signedness combination.
   logic        a_sx, b_sx;
   logic [63:0] a_ext, b_ext, prod;

   always_comb begin
      a_sx  = ((op_q == 3'b001) || (op_q == 3'b010)) && a_q[31];
      b_sx  = (op_q == 3'b001) && b_q[31];
      a_ext = {{32{a_sx}}, a_q};
      b_ext = {{32{b_sx}}, b_q};
      prod  = a_ext * b_ext;
   end

   // One restoring-division step: shift in the next dividend bit, try subtract.
   logic [32:0] div_tmp, div_sub;

   always_comb begin
      div_tmp = {rem_q, quo_q[31]};
      div_sub = div_tmp - {1'b0, dvs_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         cnt         <= 6'd0;
         op_q        <= 3'd0;
         a_q         <= 32'h0;
         b_q         <= 32'h0;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         rem_q       <= 32'h0;
         quo_q       <= 32'h0;
         dvs_q       <= 32'h0;
         prod_q      <= 64'h0;
         result_q    <= 32'h0;
         mul_valid_q <= 1'b0;
         mul_data_q  <= 32'h0;
         rob_q       <= 5'd0;
         rd_q        <= 5'd0;
      end else if (flush) begin
         state       <= StIdle;
         cnt         <= 6'd0;
         mul_valid_q <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (bus.issue_valid) begin
                  op_q    <= bus.issue_multop;
                  a_q     <= in_rs1;
                  b_q     <= in_rs2;
                  rob_q   <= bus.issue_rob_idx;
                  rd_q    <= bus.issue_rd_addr;
                  neg_a_q <= in_is_div && in_signed && in_rs1[31];
                  neg_b_q <= in_is_div && in_signed && in_rs2[31];
                  cnt     <= 6'd0;
                  if (in_div_zero) begin
                     result_q <= bus.issue_multop[1] ? in_rs1 : 32'hFFFF_FFFF;
                     state    <= StDone;
                  end else if (in_div_ovf) begin
                     result_q <= bus.issue_multop[1] ? 32'h0 : 32'h8000_0000;
                     state    <= StDone;
                  end else if (in_is_div) begin
                     rem_q <= 32'h0;
                     quo_q <= (in_signed && in_rs1[31]) ? -in_rs1 : in_rs1;
                     dvs_q <= (in_signed && in_rs2[31]) ? -in_rs2 : in_rs2;
                     state <= StDiv;
                  end else begin
                     state <= StMul;
                  end
               end
            end
            StMul: begin
               if (cnt == 6'd0) begin
                  prod_q <= prod;
                  cnt    <= 6'd1;
               end else begin
                  result_q <= (op_q == 3'b000) ? prod_q[31:0] : prod_q[63:32];
                  cnt      <= 6'd0;
                  state    <= StDone;
               end
            end
            StDiv: begin
               if (!div_sub[32]) begin
                  rem_q <= div_sub[31:0];
                  quo_q <= {quo_q[30:0], 1'b1};
               end else begin
                  rem_q <= div_tmp[31:0];
                  quo_q <= {quo_q[30:0], 1'b0};
               end
               if (cnt == 6'd31) begin
                  cnt   <= 6'd0;
                  state <= StFix;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            StFix: begin
               if (op_q[1]) begin
                  result_q <= neg_a_q ? -rem_q : rem_q;
               end else begin
                  result_q <= (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
               end
               state <= StDone;
            end
            StDone: begin
               // First DONE cycle loads the output register; the grant is honoured
               // only once the result is actually visible on the lane.
               if (!mul_valid_q) begin
                  mul_valid_q <= 1'b1;
                  mul_data_q  <= result_q;
               end else if (bus.cdb_ready) begin
                  mul_valid_q <= 1'b0;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.issue_ready = (state == StIdle);
   assign bus.mul_valid   = mul_valid_q;
   assign bus.mul_data    = mul_data_q;
   assign bus.mul_rob_idx = rob_q;
   assign bus.mul_rd_addr = rd_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide functional unit for the out-of-order core. It accepts one `mult_ops` operation at a time from the mul reservation station and computes MUL/MULH/MULHSU/MULHU with a fixed short latency, and DIV/DIVU/REM/REMU with a 32-iteration restoring divider. It drives the mul lane of the CDB (`mul_valid`/`mul_data`/`mul_rob_idx`/`mul_rd_addr`) and holds the result there until the CDB arbiter accepts it.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits and ROB/register indices at 5 bits.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  pipeline flush (CDB flush); kills any in-flight operation
- `issue_valid`  in  1  reservation station presents an operation
- `issue_ready`  out  1  unit can accept; high only in IDLE
- `issue_multop`  in  3  `mult_ops` encoding (mul=000 … remu=111)
- `issue_rs1_data`  in  32  operand A (dividend / multiplicand)
- `issue_rs2_data`  in  32  operand B (divisor / multiplier)
- `issue_rob_idx`  in  5  destination ROB index, returned unchanged
- `issue_rd_addr`  in  5  destination architectural register, returned unchanged
- `cdb_ready`  in  1  CDB arbiter grants the mul lane this cycle
- `mul_valid`  out  1  result valid on the CDB mul lane
- `mul_data`  out  32  result
- `mul_rob_idx`  out  5  latched `issue_rob_idx`
- `mul_rd_addr`  out  5  latched `issue_rd_addr`

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE. A 6-bit iteration counter drives both MUL and DIV.
- Accept: the unit accepts when `issue_valid & issue_ready & !flush` at a rising edge. The opcode, operands, `rob_idx` and `rd_addr` are latched on acceptance; the `issue_*` inputs are don't-care afterwards.
- On acceptance, the next state is:
  - MUL for ops 000–011;
  - DONE directly for divide special cases;
  - DIV for all other divides.
- MUL: the unit forms the 64-bit product of sign-/zero-extended operands:
  - mul: rs1 and rs2 each signed/unsigned as irrelevant; result is the low 32 bits;
  - mulh: signed×signed, result is the high 32 bits;
  - mulhsu: signed rs1 × unsigned rs2, high 32 bits;
  - mulhu: unsigned×unsigned, high 32 bits.
  - It stays in MUL for 2 cycles (pipelined multiplier allowed), then goes to DONE.
- DIV: restoring division on magnitudes, 1 quotient bit per cycle for 32 cycles. div/rem take the absolute value of signed operands; divu/remu use the operands as-is. After 32 cycles the FSM goes to FIX.
- FIX: applies signs.
  - Quotient is negated when the operand signs differ (div only).
  - Remainder takes the sign of the dividend (rem only).
  - Then goes to DONE.
- Special cases, resolved at acceptance, with no iteration:
  - divisor = 0: div/divu return 0xFFFFFFFF; rem/remu return rs1.
  - div with 0x80000000 / 0xFFFFFFFF returns 0x80000000; rem with the same operands returns 0.
- DONE: `mul_valid`=1 with `mul_data`/`mul_rob_idx`/`mul_rd_addr` stable until an edge with `cdb_ready`=1, then the FSM goes to IDLE. The unit does not accept in the DONE cycle.
- Flush: synchronous and highest priority. Any state goes to IDLE; `mul_valid` is 0 from the next cycle. A result in DONE is discarded even if `cdb_ready` is high in the same cycle. An issue in the flush cycle is ignored.
- Reset (asynchronous, at any time, including mid-operation): state IDLE, counter 0, `mul_valid`=0, `mul_data`=0, `mul_rob_idx`=0, `mul_rd_addr`=0. `issue_ready`=1 once in IDLE.

## Timing
- `issue_ready` is combinational from the state (IDLE only).
- Let T be the acceptance edge. `mul_valid` rises after:
  - edge T+3 for multiplies;
  - edge T+34 for normal divides (32 iterations + FIX);
  - edge T+1 for divide special cases.
- Minimum result occupancy is 1 cycle (when `cdb_ready` is already high). The earliest next acceptance is the edge after the handoff edge.
- Throughput is one operation in flight; there is no overlap.

## Test plan
- Reset then mul 7 × 0xFFFFFFFD, rob_idx=5, rd=3 -> `mul_valid` after T+3, `mul_data`=0xFFFFFFEB, rob_idx 5, rd 3; `issue_ready`=0 from T to the handoff edge.
- High-half multiplies:
  - mulh 0x80000000 × 0x80000000 -> 0x40000000;
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE;
  - mulhsu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides, each with valid after T+34:
  - div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD;
  - rem same operands -> 0xFFFFFFFF;
  - divu 100 / 7 -> 14;
  - remu 100 / 7 -> 2.
- Special cases, each with valid after T+1:
  - div 5 / 0 -> 0xFFFFFFFF;
  - remu 5 / 0 -> 5;
  - div 0x80000000 / 0xFFFFFFFF -> 0x80000000;
  - rem same operands -> 0.
- Backpressure: hold `cdb_ready`=0 for 5 cycles in DONE -> `mul_valid` and all outputs remain stable and `issue_ready`=0. Raise `cdb_ready` -> IDLE next cycle, and a new issue is accepted on the following edge.
- Flush and reset mid-operation:
  - `flush` at T+10 of a div -> `mul_valid` never asserts for it and `issue_ready`=1 next cycle; a new mul then completes at T'+3.
  - `rst` asserted asynchronously mid-MUL -> all outputs are 0 immediately.
